sr_mdu: RTL and testbench
=========================

SR_MDU -- requirements
Module: sr_mdu

Interface
- REQ-001: WIDTH, default 32, operand/result width; iteration count equals WIDTH.
- REQ-002: clk  input  1  single clock; all state changes on rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: start  input  1  level request from CPU control; held high while the extension instruction is in decode.
- REQ-005: op  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU; all unsigned.
- REQ-006: a  input  WIDTH  first operand (rs1 value).
- REQ-007: b  input  WIDTH  second operand (rs2 value).
- REQ-008: result  output  WIDTH  operation result; valid while ready=1.
- REQ-009: ready  output  1  one-cycle completion pulse; CPU uses it for register write enable and PC write enable.

Function
- REQ-010: The state machine SHALL have exactly three states: IDLE, BUSY and DONE.
- REQ-011: IDLE with start=1 at an edge SHALL latch op, a and b, clear the accumulators and counter, and go to BUSY.
- REQ-012: IDLE with start=0 SHALL remain in IDLE.
- REQ-013: BUSY SHALL perform one iteration per cycle and increment the counter from 0 to WIDTH-1.
- REQ-014: BUSY SHALL move to DONE on the edge that completes iteration WIDTH-1.
- REQ-015: DONE SHALL assert ready for exactly one cycle and return to IDLE on the next edge, unconditionally.
- REQ-016: Latency: if start first rises in cycle 0 (IDLE), cycles 1..WIDTH SHALL be BUSY and ready SHALL be 1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- REQ-017: ready SHALL be a registered-state decode (state==DONE), with no combinational path from start, op, a or b.
- REQ-018: MUL/MULHU SHALL use a shift-add scheme with a 2*WIDTH-bit product; MUL returns bits [WIDTH-1:0] and MULHU returns bits [2*WIDTH-1:WIDTH].
- REQ-019: DIVU/REMU SHALL use restoring division producing one quotient bit per iteration; DIVU returns the quotient and REMU returns the remainder.
- REQ-020: Divide by zero (b=0) SHALL return all-ones for DIVU and a for REMU; this falls out of the restoring algorithm, with no special case and no exception.
- REQ-021: Changes on op, a or b while in BUSY or DONE SHALL be ignored, because the latched copies are used.
- REQ-022: start=0 sampled in BUSY SHALL abort the operation: go to IDLE, no ready pulse, result unchanged.
- REQ-023: Back-to-back operations: start held high through DONE SHALL NOT re-trigger in DONE. The next operation is accepted in the following IDLE cycle, using the operands present then (the next instruction's).
- REQ-024: result SHALL be updated only on the BUSY->DONE edge and SHALL hold its value until the next completed operation.
- REQ-025: Arithmetic SHALL be modulo 2^WIDTH for outputs; internal carries SHALL NOT be truncated before selection.

Reset
- REQ-026: rst=1 at an edge SHALL force IDLE, ready=0, result=0, counter=0 and clear the latched operands and accumulators.
- REQ-027: rst SHALL take priority over start and over any in-flight operation; no ready pulse SHALL follow reset mid-operation.
- REQ-028: In the first cycle after rst falls with start=1, an operation SHALL be accepted as from IDLE.

Verification
- REQ-029: MUL: a=7, b=6, start held -> ready=1 exactly in cycle 33 with result=42; ready=0 in all other cycles.
- REQ-030: MULHU: a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
- REQ-031: DIVU then REMU: a=100, b=7 -> DIVU result=14, REMU result=2.
- REQ-032: Divide by zero: a=0x12345678, b=0 -> DIVU result=0xFFFFFFFF, REMU result=0x12345678.
- REQ-033: Back-to-back: start held high across two MUL operations (3*5, then 9*9), operands switched the cycle after ready -> ready pulses in cycles 33 and 67 with results 15 and 81; no extra pulse.
- REQ-034: Reset/abort: rst=1 at BUSY cycle 10 -> state=IDLE, result=0, no ready; separately, start dropped at BUSY cycle 10 -> IDLE, no ready, previous result retained.

Source files
------------

// File: rtl/sr_mdu_if.sv
// Request/result bundle between the CPU control path and the serial MDU.
// The CPU drives the request side; the MDU returns result and ready.
interface sr_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             ready;

  modport master (output start, op, a, b, input result, ready);
  modport slave  (input start, op, a, b, output result, ready);
endinterface

// File: rtl/sr_mdu.sv
// Serial unsigned multiply/divide unit: one iteration per cycle, WIDTH
// iterations per operation, one-cycle ready pulse on completion.
// A single 2*WIDTH accumulator is shared by both algorithms:
//   multiply: {partial product high, multiplier shifting out low}
//   divide:   {partial remainder,    dividend/quotient shifting}
// After WIDTH steps the low half holds MUL/DIVU and the high half holds
// MULHU/REMU, so op[0] alone selects the returned half.
module sr_mdu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  sr_mdu_if.slave    bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q;
  logic               last;

  // Datapath step terms: carry bit of the add and the borrow of the
  // trial subtract are kept, never truncated before use.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // One iteration of shift-add multiply or restoring divide.
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_nxt   = acc;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){acc[0]}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    if (!op_q[1]) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (div_diff[WIDTH+1]) begin
      acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Next-state decode; dropping start in BUSY aborts, DONE always leaves.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (!bus.start) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, iteration counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q <= bus.op;
          a_q  <= bus.a;
          b_q  <= bus.b;
          acc  <= {{WIDTH{1'b0}}, (bus.op[1] ? bus.a : bus.b)};
          cnt  <= '0;
        end
        BUSY: if (bus.start) begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) result_q <= op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = (state == DONE);
endmodule

// File: tb/tb_sr_mdu.sv
// Directed bench for sr_mdu: latency, arithmetic, divide by zero,
// back-to-back, reset and abort behaviour. Inputs change and outputs are
// sampled on the falling edge; cycle N is the period after rising edge N.
module tb_sr_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  sr_mdu_if #(.WIDTH(W)) bus ();
  sr_mdu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Issue one operation from IDLE (cycle 0) with start held until ready is
  // seen; report the first ready cycle, its result and the pulse count.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit scramble, output logic [W-1:0] res,
                       output int ready_cyc, output int pulses);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    ready_cyc = 0; pulses = 0; res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        pulses++;
        if (ready_cyc == 0) begin ready_cyc = c; res = bus.result; end
        bus.start = 1'b0;
      end
      if (scramble && c == 5) begin
        bus.op = ~op; bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0003;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1; bus.b = 32'd1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    vectors++;
    if (bus.result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    bus.start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [W-1:0] res; int rc, np;
    do_op(2'b00, 32'd7, 32'd6, 1'b0, res, rc, np);
    vectors++;
    if (rc !== 33) begin miscompares++; $display("FAIL mul_latency: got cycle %0d expected 33", rc); end
    vectors++;
    if (np !== 1) begin miscompares++; $display("FAIL mul_pulses: got %0d expected 1", np); end
    vectors++;
    if (res !== 32'd42) begin miscompares++; $display("FAIL mul_7x6: got %h expected %h", res, 32'd42); end
  endtask

  task automatic test_mulhu();
    logic [W-1:0] res; int rc, np;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, rc, np);
    vectors++;
    if (res !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mulhu_max: got %h expected fffffffe", res); end
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, rc, np);
    vectors++;
    if (res !== 32'h0000_0001) begin miscompares++; $display("FAIL mul_max: got %h expected 00000001", res); end
  endtask

  // Operands and op are scrambled mid-operation; latched copies must win.
  task automatic test_div();
    logic [W-1:0] res; int rc, np;
    do_op(2'b10, 32'd100, 32'd7, 1'b1, res, rc, np);
    vectors++;
    if (res !== 32'd14) begin miscompares++; $display("FAIL divu_100_7: got %h expected %h", res, 32'd14); end
    vectors++;
    if (rc !== 33) begin miscompares++; $display("FAIL divu_latency: got cycle %0d expected 33", rc); end
    do_op(2'b11, 32'd100, 32'd7, 1'b1, res, rc, np);
    vectors++;
    if (res !== 32'd2) begin miscompares++; $display("FAIL remu_100_7: got %h expected %h", res, 32'd2); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] res; int rc, np;
    do_op(2'b10, 32'h1234_5678, 32'd0, 1'b0, res, rc, np);
    vectors++;
    if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu_by_zero: got %h expected ffffffff", res); end
    do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, res, rc, np);
    vectors++;
    if (res !== 32'h1234_5678) begin miscompares++; $display("FAIL remu_by_zero: got %h expected 12345678", res); end
  endtask

  task automatic test_back_to_back();
    int np = 0; int rc[2] = '{0, 0}; logic [W-1:0] rs[2];
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (np < 2) begin rc[np] = c; rs[np] = bus.result; end
        np++;
        if (c >= 67) bus.start = 1'b0;
      end
      if (c == 34) begin bus.a = 32'd9; bus.b = 32'd9; end
    end
    bus.start = 1'b0;
    vectors++;
    if (np !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 2", np); end
    vectors++;
    if (rc[0] !== 33 || rs[0] !== 32'd15) begin miscompares++; $display("FAIL b2b_first: got cycle %0d result %h expected cycle 33 result %h", rc[0], rs[0], 32'd15); end
    vectors++;
    if (rc[1] !== 67 || rs[1] !== 32'd81) begin miscompares++; $display("FAIL b2b_second: got cycle %0d result %h expected cycle 67 result %h", rc[1], rs[1], 32'd81); end
  endtask

  // Reset in BUSY cycle 10 with start still high: the operation is dropped,
  // then a fresh one is accepted right after reset falls (ready in 11+33).
  task automatic test_reset_mid_op();
    int np = 0; int rc = 0; logic [W-1:0] rs;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (bus.ready) begin np++; if (rc == 0) begin rc = c; rs = bus.result; end bus.start = 1'b0; end
      if (c == 10) rst = 1'b1;
      if (c == 11) begin
        vectors++;
        if (bus.result !== 32'd0) begin miscompares++; $display("FAIL rst_mid_result: got %h expected 0", bus.result); end
        rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (np !== 1 || rc !== 44) begin miscompares++; $display("FAIL rst_mid_ready: got %0d pulses first at cycle %0d expected 1 at cycle 44", np, rc); end
    vectors++;
    if (rs !== 32'd25) begin miscompares++; $display("FAIL rst_then_accept: got %h expected %h", rs, 32'd25); end
  endtask

  task automatic test_abort();
    logic [W-1:0] res; int rc, np;
    do_op(2'b00, 32'd6, 32'd7, 1'b0, res, rc, np);
    np = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd8; bus.b = 32'd8;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.ready) np++;
      if (c == 10) bus.start = 1'b0;
    end
    vectors++;
    if (np !== 0) begin miscompares++; $display("FAIL abort_ready: got %0d pulses expected 0", np); end
    vectors++;
    if (bus.result !== 32'd42) begin miscompares++; $display("FAIL abort_result_kept: got %h expected %h", bus.result, 32'd42); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
